// File: rtl/demux32bit_1_2.sv
// demux32bit_1_2: registered 1-to-2 demultiplexer for 32-bit words.
// A single producer offers words with a route select bit X; each accepted
// word lands in the one-entry holding slot of port A (X=0) or port B (X=1).
// Each slot has its own valid/ready handshake toward its consumer and a
// wrapping count of the words it has accepted since reset.

// DemuxPortSlot: one output port's holding register, EMPTY/FULL state,
// handshake and transfer counter. The top instantiates two of these.
module DemuxPortSlot #(
    parameter int WIDTH = 32,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] loadData_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             canLoad_o,
    output logic [CW-1:0]    count_o
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    slot_state_e      state_q;
    slot_state_e      state_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    // Slot state register; reset drops any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next slot state: a load always leaves the slot FULL (even when the old
    // word drains in the same edge); otherwise a taken word empties it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (load_i) begin
                    state_d = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (load_i) begin
                    state_d = SLOT_FULL;
                end else if (ready_i) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: begin
                state_d = SLOT_EMPTY;
            end
        endcase
    end

    // Slot outputs: valid mirrors FULL, and the slot can take a new word
    // whenever it is empty or its current word is leaving this cycle.
    always_comb begin
        valid_o   = (state_q == SLOT_FULL);
        canLoad_o = (state_q == SLOT_EMPTY) | ready_i;
        data_o    = data_q;
        count_o   = count_q;
    end

    // Holding register next value; data keeps its last word after a drain.
    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = loadData_i;
        end
    end

    // Holding register storage, cleared by reset so no stale word survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    // Transfer counter next value; wraps naturally at 2^CW.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = count_q + CW'(1);
        end
    end

    // Transfer counter storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// Top level: routes the producer's word to one of the two slots.
module demux32bit_1_2 #(
    parameter int WIDTH = 32,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             X,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CW-1:0]    a_count,
    output logic [CW-1:0]    b_count
);

    logic aCanLoad;
    logic bCanLoad;
    logic loadA;
    logic loadB;

    // Input handshake: readiness depends only on the selected slot, never on
    // in_valid, so the producer may look at in_ready before committing.
    always_comb begin
        in_ready = X ? bCanLoad : aCanLoad;
        loadA    = in_valid & in_ready & ~X;
        loadB    = in_valid & in_ready & X;
    end

    DemuxPortSlot #(
        .WIDTH(WIDTH),
        .CW   (CW)
    ) uSlotA (
        .clk       (clk),
        .rst       (rst),
        .load_i    (loadA),
        .loadData_i(in_data),
        .ready_i   (a_ready),
        .data_o    (a_data),
        .valid_o   (a_valid),
        .canLoad_o (aCanLoad),
        .count_o   (a_count)
    );

    DemuxPortSlot #(
        .WIDTH(WIDTH),
        .CW   (CW)
    ) uSlotB (
        .clk       (clk),
        .rst       (rst),
        .load_i    (loadB),
        .loadData_i(in_data),
        .ready_i   (b_ready),
        .data_o    (b_data),
        .valid_o   (b_valid),
        .canLoad_o (bCanLoad),
        .count_o   (b_count)
    );

endmodule

// File: tb/tb_demux32bit_1_2.sv
// tb_demux32bit_1_2: scenario tasks plus a randomized run, all checked
// against a small behavioural model of the two holding slots.
module tb_demux32bit_1_2;

    localparam int WIDTH = 32;
    localparam int CW    = 4;
    localparam int CMASK = (1 << CW) - 1;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             routeSel;
    logic             in_ready;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [CW-1:0]    a_count;
    logic [CW-1:0]    b_count;

    int testsRun = 0;
    int testsFailed = 0;

    // Behavioural model: each port holds at most one word.
    logic             mAValid, mBValid;
    logic [WIDTH-1:0] mAData, mBData;
    int               mACount, mBCount;

    demux32bit_1_2 #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_data (in_data),
        .in_valid(in_valid),
        .X       (routeSel),
        .in_ready(in_ready),
        .a_data  (a_data),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .b_data  (b_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .a_count (a_count),
        .b_count (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic modelInReady();
        if (routeSel) return !mBValid || b_ready;
        return !mAValid || a_ready;
    endfunction

    // Advance one clock: model decides from the inputs present before the edge.
    task automatic tick();
        logic rdy, accA, accB;
        rdy  = modelInReady();
        accA = in_valid && rdy && !routeSel;
        accB = in_valid && rdy && routeSel;
        @(posedge clk);
        if (rst) begin
            mAValid = 0; mBValid = 0; mAData = '0; mBData = '0;
            mACount = 0; mBCount = 0;
        end else begin
            if (accA) begin
                mAData = in_data; mAValid = 1; mACount = (mACount + 1) & CMASK;
            end else if (mAValid && a_ready) begin
                mAValid = 0;
            end
            if (accB) begin
                mBData = in_data; mBValid = 1; mBCount = (mBCount + 1) & CMASK;
            end else if (mBValid && b_ready) begin
                mBValid = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 0; routeSel = 0; a_ready = 0; b_ready = 0; in_data = '0;
        tick(); tick();
        testsRun++;
        if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_in_ready_during: got %b want 1", in_ready); end
        rst = 0; #1;
        testsRun++;
        if ({a_valid, b_valid} !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_valids: got %b want 00", {a_valid, b_valid}); end
        testsRun++;
        if (a_data !== '0 || b_data !== '0) begin testsFailed++; $display("[TB] FAIL reset_data: got %h/%h want 0/0", a_data, b_data); end
        testsRun++;
        if (a_count !== '0 || b_count !== '0) begin testsFailed++; $display("[TB] FAIL reset_counts: got %0d/%0d want 0/0", a_count, b_count); end
        testsRun++;
        if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
        in_data = 32'hDEADBEEF; routeSel = 0; in_valid = 1; a_ready = 1;
        tick();
        in_valid = 0;
        testsRun++;
        if (a_valid !== 1'b1 || a_data !== 32'hDEADBEEF) begin testsFailed++; $display("[TB] FAIL route_a: got v=%b d=%h want v=1 d=deadbeef", a_valid, a_data); end
        testsRun++;
        if (b_valid !== 1'b0 || a_count !== 4'd1) begin testsFailed++; $display("[TB] FAIL route_a_side: got bv=%b ac=%0d want bv=0 ac=1", b_valid, a_count); end
    endtask

    task automatic test_backpressure_b();
        in_valid = 0; a_ready = 1; b_ready = 1;
        tick();
        b_ready = 0; in_data = 32'h11111111; routeSel = 1; in_valid = 1; #1;
        testsRun++;
        if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_first_ready: got %b want 1", in_ready); end
        tick();
        in_data = 32'h22222222; #1;
        for (int i = 0; i < 3; i++) begin
            testsRun++;
            if (in_ready !== 1'b0 || b_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_hold_%0d: got rdy=%b bv=%b want rdy=0 bv=1", i, in_ready, b_valid); end
            testsRun++;
            if (b_data !== 32'h11111111 || b_count !== 4'd1) begin testsFailed++; $display("[TB] FAIL bp_hold_data_%0d: got %h cnt=%0d want 11111111 cnt=1", i, b_data, b_count); end
            tick();
        end
        b_ready = 1; #1;
        testsRun++;
        if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_release_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 0;
        testsRun++;
        if (b_data !== 32'h22222222 || b_valid !== 1'b1 || b_count !== 4'd2) begin testsFailed++; $display("[TB] FAIL bp_release: got %h v=%b cnt=%0d want 22222222 v=1 cnt=2", b_data, b_valid, b_count); end
    endtask

    task automatic test_blocked_b_free_a();
        b_ready = 0; a_ready = 1; in_data = 32'h33333333; routeSel = 0; in_valid = 1; #1;
        testsRun++;
        if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL blocked_b_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 0;
        testsRun++;
        if (a_valid !== 1'b1 || a_data !== 32'h33333333 || a_count !== 4'd2) begin testsFailed++; $display("[TB] FAIL blocked_b_a: got v=%b d=%h c=%0d want v=1 d=33333333 c=2", a_valid, a_data, a_count); end
        testsRun++;
        if (b_valid !== 1'b1 || b_data !== 32'h22222222) begin testsFailed++; $display("[TB] FAIL blocked_b_b: got v=%b d=%h want v=1 d=22222222", b_valid, b_data); end
    endtask

    task automatic test_streaming();
        logic [WIDTH-1:0] qa[$];
        logic [WIDTH-1:0] qb[$];
        logic [WIDTH-1:0] w;
        int startA, startB;
        a_ready = 1; b_ready = 1; in_valid = 0;
        tick();
        startA = mACount; startB = mBCount;
        for (int i = 0; i < 8; i++) begin
            w = $urandom; in_data = w; routeSel = i[0]; in_valid = 1; #1;
            if (routeSel) qb.push_back(w); else qa.push_back(w);
            testsRun++;
            if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL stream_ready_%0d: got %b want 1", i, in_ready); end
            tick();
            testsRun++;
            if (i[0] == 1'b0) begin
                w = qa.pop_front();
                if (a_valid !== 1'b1 || a_data !== w) begin testsFailed++; $display("[TB] FAIL stream_a_%0d: got v=%b d=%h want v=1 d=%h", i, a_valid, a_data, w); end
            end else begin
                w = qb.pop_front();
                if (b_valid !== 1'b1 || b_data !== w) begin testsFailed++; $display("[TB] FAIL stream_b_%0d: got v=%b d=%h want v=1 d=%h", i, b_valid, b_data, w); end
            end
        end
        in_valid = 0;
        testsRun++;
        if (int'(a_count) !== ((startA + 4) & CMASK) || int'(b_count) !== ((startB + 4) & CMASK)) begin
            testsFailed++;
            $display("[TB] FAIL stream_counts: got %0d/%0d want %0d/%0d", a_count, b_count, (startA + 4) & CMASK, (startB + 4) & CMASK);
        end
    endtask

    task automatic test_counter_wrap();
        rst = 1; in_valid = 0;
        tick();
        rst = 0; a_ready = 1; b_ready = 1; routeSel = 0; in_valid = 1;
        for (int i = 1; i <= 17; i++) begin
            in_data = $urandom;
            tick();
            testsRun++;
            if (int'(a_count) !== (i % (1 << CW))) begin testsFailed++; $display("[TB] FAIL wrap_a_count_%0d: got %0d want %0d", i, a_count, i % (1 << CW)); end
        end
        in_valid = 0;
        testsRun++;
        if (b_count !== '0) begin testsFailed++; $display("[TB] FAIL wrap_b_count: got %0d want 0", b_count); end
    endtask

    task automatic test_mid_reset();
        a_ready = 0; b_ready = 0; in_valid = 1;
        routeSel = 0; in_data = $urandom; tick();
        routeSel = 1; in_data = $urandom; tick();
        testsRun++;
        if ({a_valid, b_valid} !== 2'b11) begin testsFailed++; $display("[TB] FAIL midrst_full: got %b want 11", {a_valid, b_valid}); end
        rst = 1; routeSel = 0; in_data = 32'hCAFEF00D;
        tick();
        rst = 0; in_valid = 0; #1;
        testsRun++;
        if ({a_valid, b_valid} !== 2'b00 || a_data !== '0 || b_data !== '0) begin testsFailed++; $display("[TB] FAIL midrst_clear: got v=%b %h/%h want v=00 0/0", {a_valid, b_valid}, a_data, b_data); end
        testsRun++;
        if (a_count !== '0 || b_count !== '0) begin testsFailed++; $display("[TB] FAIL midrst_counts: got %0d/%0d want 0/0", a_count, b_count); end
        a_ready = 1; b_ready = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            testsRun++;
            if ({a_valid, b_valid} !== 2'b00 || a_data !== '0 || b_data !== '0) begin testsFailed++; $display("[TB] FAIL midrst_stale_%0d: got v=%b %h/%h want v=00 0/0", i, {a_valid, b_valid}, a_data, b_data); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rst      = ($urandom_range(0, 39) == 0);
            in_valid = $urandom_range(0, 3) != 0;
            routeSel = $urandom_range(0, 1) == 1;
            a_ready  = $urandom_range(0, 2) != 0;
            b_ready  = $urandom_range(0, 2) != 0;
            in_data  = $urandom;
            #1;
            testsRun++;
            if (in_ready !== modelInReady()) begin testsFailed++; $display("[TB] FAIL rand_in_ready_%0d: got %b want %b", i, in_ready, modelInReady()); end
            tick();
            testsRun++;
            if (a_valid !== mAValid || a_data !== mAData || int'(a_count) !== mACount) begin
                testsFailed++;
                $display("[TB] FAIL rand_port_a_%0d: got v=%b d=%h c=%0d want v=%b d=%h c=%0d", i, a_valid, a_data, a_count, mAValid, mAData, mACount);
            end
            testsRun++;
            if (b_valid !== mBValid || b_data !== mBData || int'(b_count) !== mBCount) begin
                testsFailed++;
                $display("[TB] FAIL rand_port_b_%0d: got v=%b d=%h c=%0d want v=%b d=%h c=%0d", i, b_valid, b_data, b_count, mBValid, mBData, mBCount);
            end
        end
        rst = 0; in_valid = 0;
    endtask

    initial begin
        mAValid = 0; mBValid = 0; mAData = '0; mBData = '0; mACount = 0; mBCount = 0;
        rst = 1; in_valid = 0; routeSel = 0; a_ready = 0; b_ready = 0; in_data = '0;
        test_reset();
        test_backpressure_b();
        test_blocked_b_free_a();
        test_streaming();
        test_counter_wrap();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/demux32bit_1_2.md
# demux32bit_1_2

Registered 1-to-2 demultiplexer for 32-bit words: the distribution-side counterpart of the datapath 2:1 select. Each accepted input word is routed by a select bit to one of two output ports, A or B. Each output port has a one-entry holding register with a valid/ready handshake and a wrapping transfer counter. The block feeds two consumers (e.g. two write-back or memory-side paths) from a single producer.

## Interface
- WIDTH, 32, data word width
- CW, 16, width of each per-port transfer counter
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_data  input  WIDTH  word offered by producer
- in_valid  input  1  producer has a word
- X  input  1  route select; 0 -> port A, 1 -> port B; sampled with in_data
- in_ready  output  1  block accepts the word this cycle (combinational)
- a_data  output  WIDTH  port A holding register
- a_valid  output  1  port A holds a word
- a_ready  input  1  port A consumer takes the word
- b_data  output  WIDTH  port B holding register
- b_valid  output  1  port B holds a word
- b_ready  input  1  port B consumer takes the word
- a_count  output  CW  words accepted into A since reset, wraps
- b_count  output  CW  words accepted into B since reset, wraps

## Operation
- Per-port slot states: EMPTY (valid=0) and FULL (valid=1). No other FSM.
- in_ready = X ? (!b_valid | b_ready) : (!a_valid | a_ready). in_ready depends on X, the target valid and the target ready only. It must not depend on in_valid.
- Accept: in_valid & in_ready at a rising edge.
  - Target data register loads in_data.
  - Target valid <= 1.
  - Target count increments by 1, modulo 2^CW.
- Drain: x_valid & x_ready with no load into that port. x_valid <= 0. x_data holds its last value.
- Load and drain on the same port in the same cycle: the old word leaves, the new word loads, and valid stays 1.
- Non-selected port: unaffected by the input side. It may drain independently in the same cycle as a load into the other port.
- FULL and not ready: x_data and x_valid stay stable until the handshake completes.
- in_valid=0: no state change except drains. X is ignored.
- Counter wrap: 2^CW-1 -> 0 on the next accept. No saturation or flag.
- No reordering within a port. Words sent to different ports have no mutual ordering guarantee.

## Timing
- Reset (rst=1 at a rising edge), all outputs: a_valid=0, b_valid=0, a_data=0, b_data=0, a_count=0, b_count=0.
  - in_ready during reset follows its formula with both valids at 0, so it reads 1.
  - Accepts in the reset cycle are discarded.
- Reset mid-operation: held words are dropped and counts are cleared. There is no partial state.
- Latency: a word accepted at edge N is visible on x_data/x_valid after edge N, and can be consumed at edge N+1.
- Throughput: 1 word/cycle per port while the consumer holds ready=1. Sustained 1 word/cycle is possible overall.
- Backpressure: a FULL, non-ready target holds in_ready=0. The producer must hold in_data/X/in_valid until accepted. The block does not require this hold, but it accepts nothing while in_ready=0.

## Test plan
- Reset, route to A: assert rst for 2 cycles, then check all outputs are 0 and in_ready=1. Then offer in_data=0xDEADBEEF with X=0 and a_ready=1. Required: a_valid=1 and a_data=0xDEADBEEF one cycle later, b_valid stays 0, a_count=1.
- Backpressure on B: b_ready=0, offer 0x11111111 with X=1, then 0x22222222 with X=1. Required:
  - the first word is accepted;
  - in_ready=0 while b_valid=1;
  - b_data stays 0x11111111.
  - Then raise b_ready. Required: 0x22222222 loads in the same edge that 0x11111111 drains, b_valid stays 1, b_count=2.
- Blocked B, free A: B is FULL with b_ready=0. Offer 0x33333333 with X=0 and a_ready=1. Required: in_ready=1, A receives the word, and B data and valid are unchanged.
- Streaming: 8 back-to-back words alternating X=0/1, both readies held at 1. Required:
  - in_ready=1 every cycle;
  - each port sees its 4 words in order;
  - a_count=4 and b_count=4.
- Counter wrap: with CW=4, push 17 words to A. Required: a_count sequence 1..15, 0, 1, and b_count=0.
- Mid-operation reset: both ports FULL with readies low. Pulse rst for one cycle. Required: both valids=0, both data=0 and both counts=0 the next cycle, and no stale word reappears.
